palt_sysid_checker: RTL and testbench
=====================================

// Module: palt_sysid_checker
// PURPOSE
//  Avalon-MM read master that sequences the 2-word system-ID slave.
//  - Word 0 (addr 0) is the system ID; word 1 (addr 1) is the build timestamp.
//  - Runs at boot (or on request), reads both words and compares them to the
//    expected values.
//  - Publishes pass/fail flags to the board-level health logic and the LED/boot
//    gate. Sits between the reset controller and the sysid control_slave.
// PARAMETERS
//  EXPECTED_ID    32'd8           expected word at address 0
//  EXPECTED_TS    32'd1649502956  expected word at address 1
//  READ_LATENCY   0               slave read latency in cycles after accept (0..3)
//  TIMEOUT        255             max cycles per read, issue to capture (1..65535)
//  AUTO_START     1               1: check starts automatically after reset release
// PORTS
//  clock          in   1   system clock, single domain
//  reset          in   1   asynchronous, active-high reset
//  start          in   1   pulse; requests a (re)check, honoured only when not busy
//  avm_address    out  1   0 = ID word, 1 = timestamp word
//  avm_read       out  1   Avalon read strobe
//  avm_waitrequest in  1   slave stall; tie 0 for the zero-wait sysid slave
//  avm_readdata   in   32  slave read data
//  busy           out  1   check in progress
//  done           out  1   check finished; held until next start
//  id_ok          out  1   captured ID == EXPECTED_ID
//  ts_ok          out  1   captured timestamp == EXPECTED_TS
//  match          out  1   id_ok & ts_ok & ~timeout_err
//  timeout_err    out  1   a read exceeded TIMEOUT cycles
//  id_value       out  32  last captured ID word
//  ts_value       out  32  last captured timestamp word
// BEHAVIOUR
//  - Reset: every output is 0 and state is IDLE. Reset is asynchronous, so
//    avm_read drops immediately, even mid-read.
//  - States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE.
//  - IDLE -> RD_ID on the first edge after reset release if AUTO_START=1,
//    else on start. In DONE, start -> RD_ID. Start is ignored in any other state.
//  - On entry to RD_ID: done, id_ok, ts_ok, match and timeout_err clear on the
//    same edge; busy=1.
//  - RD_x: avm_read=1; avm_address=0 for ID, 1 for TS. Address and read are held
//    stable while avm_waitrequest=1.
//  - Accept = avm_read & ~avm_waitrequest.
//  - READ_LATENCY=0: capture avm_readdata on the accept edge and go to the next
//    state.
//  - READ_LATENCY=N>0: deassert read after accept; LAT_x counts N cycles, then
//    captures and moves on.
//  - Sequence: RD_ID/LAT_ID capture -> RD_TS; RD_TS/LAT_TS capture -> DONE.
//  - The compare flags are registered on the transition into DONE, where done=1
//    and busy=0.
//  - Zero-wait, latency 0, AUTO_START: avm_read is high on edges 1-2 after reset
//    release; done rises on edge 3.
//  - Timeout: the per-read counter resets at each read issue and increments each
//    cycle until capture. If it reaches TIMEOUT:
//    read drops, timeout_err=1, id_ok=ts_ok=match=0, -> DONE.
//  - id_value/ts_value keep their last captured value across the timeout path.
//  - id_value/ts_value update only on capture and are not cleared by start.
//  - Start asserted on the same edge that enters DONE is ignored; it is sampled
//    only while already in IDLE or DONE.
//  - Compare is full 32-bit equality; no masking.
// STRUCTURE
//  - palt_sysid_pkg holds:
//    - the state enum;
//    - ADDR_ID=1'b0 and ADDR_TS=1'b1;
//    - a 16-bit timer width constant.
//  - One sub-module, palt_sysid_rd_timer: load/count/expire for both the latency
//    and the timeout counters.
//  - FSM, capture registers and compare logic stay in the top level.
// TESTING
//  1. Zero-wait, latency 0, slave returns 8 / 1649502956 -> done on edge 3,
//     match=1, id_value=8.
//  2. Slave returns ID=9 -> id_ok=0, ts_ok=1, match=0, done=1,
//     timeout_err=0, id_value=9.
//  3. waitrequest held 4 cycles on each read, READ_LATENCY=2 -> addr/read stable
//     while stalled, done on edge 14, match=1.
//  4. TIMEOUT=10, waitrequest stuck 1 -> read drops after 10 cycles,
//     timeout_err=1, match=0, done=1.
//  5. Reset asserted mid-RD_TS -> avm_read=0 asynchronously, all flags 0.
//     After release with AUTO_START=1 the full check reruns and passes.
//  6. AUTO_START=0: start pulse while busy is ignored. Start in DONE clears done
//     next edge and repeats the check; start coincident with entering DONE does
//     not restart.

Source files
------------

// File: rtl/palt_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package palt_sysid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StLatId,
    StRdTs,
    StLatTs,
    StDone
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Width of the per-read latency and timeout counters.
  localparam int unsigned TimerW = 16;

endpackage

// File: rtl/palt_sysid_rd_timer.sv
// Load/count/expire counter, used for both the read-latency and the per-read timeout.
module palt_sysid_rd_timer
  import palt_sysid_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [TimerW-1:0] limit_i,
  output logic              last_o
);

  logic [TimerW-1:0] cnt_q;

  // Counter restarts from zero on load and advances while enabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // High on the cycle whose closing edge brings the count up to limit_i.
  assign last_o = (cnt_q == (limit_i - TimerW'(1)));

endmodule

// File: rtl/palt_sysid_checker.sv
// Avalon-MM read master that reads the 2-word sysid slave and checks both words.
module palt_sysid_checker
  import palt_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'd8,
  parameter logic [31:0] EXPECTED_TS  = 32'd1649502956,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        match,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam bit              NoLat    = (READ_LATENCY == 0);
  localparam logic [TimerW-1:0] LatLimit = TimerW'(READ_LATENCY);
  localparam logic [TimerW-1:0] TmoLimit = TimerW'(TIMEOUT);

  state_e state_q;

  logic accept, in_read, in_lat, in_id;
  logic go, cap, lat_load, tmo;
  logic lat_last, tmo_last;

  // Transfer decode: issue, accept, capture and timeout conditions for this cycle.
  always_comb begin
    accept   = avm_read & ~avm_waitrequest;
    in_read  = (state_q == StRdId) || (state_q == StRdTs);
    in_lat   = (state_q == StLatId) || (state_q == StLatTs);
    in_id    = (state_q == StRdId) || (state_q == StLatId);
    go       = ((state_q == StIdle) && (AUTO_START || start)) || ((state_q == StDone) && start);
    cap      = (in_read && accept && NoLat) || (in_lat && lat_last);
    lat_load = in_read && accept && !NoLat;
    // Capture wins over a timeout landing on the same edge.
    tmo      = (in_read || in_lat) && tmo_last && !cap;
  end

  palt_sysid_rd_timer u_lat_timer (
    .clock   (clock),
    .reset   (reset),
    .load_i  (lat_load),
    .en_i    (in_lat),
    .limit_i (LatLimit),
    .last_o  (lat_last)
  );

  // Timeout counter restarts at each read issue (start of ID and TS reads).
  palt_sysid_rd_timer u_tmo_timer (
    .clock   (clock),
    .reset   (reset),
    .load_i  (go || (cap && in_id)),
    .en_i    (in_read || in_lat),
    .limit_i (TmoLimit),
    .last_o  (tmo_last)
  );

  // Sequencer FSM with registered bus strobes, status flags and capture registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      avm_address <= ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      match       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else if (go) begin
      state_q     <= StRdId;
      avm_address <= ADDR_ID;
      avm_read    <= 1'b1;
      busy        <= 1'b1;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      match       <= 1'b0;
      timeout_err <= 1'b0;
    end else if (tmo) begin
      state_q     <= StDone;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b1;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      match       <= 1'b0;
      timeout_err <= 1'b1;
    end else if (cap && in_id) begin
      state_q     <= StRdTs;
      id_value    <= avm_readdata;
      avm_address <= ADDR_TS;
      avm_read    <= 1'b1;
    end else if (cap) begin
      // ID was captured earlier; the TS word is compared as it is captured.
      state_q     <= StDone;
      ts_value    <= avm_readdata;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b1;
      id_ok       <= (id_value == EXPECTED_ID);
      ts_ok       <= (avm_readdata == EXPECTED_TS);
      match       <= (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
    end else if (lat_load) begin
      state_q  <= in_id ? StLatId : StLatTs;
      avm_read <= 1'b0;
    end
  end

endmodule

// File: tb/tb_palt_sysid_checker.sv
// Directed bench: three checker instances (default, stalled/latency/timeout, manual start).
module tb_palt_sysid_checker;

  localparam logic [31:0] ExpId = 32'd8;
  localparam logic [31:0] ExpTs = 32'd1649502956;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        start [3];
  logic        wreq  [3];
  logic        addr  [3];
  logic        rd    [3];
  logic [31:0] rdata [3];
  logic        busy  [3];
  logic        done  [3];
  logic        idok  [3];
  logic        tsok  [3];
  logic        mtch  [3];
  logic        tmerr [3];
  logic [31:0] idv   [3];
  logic [31:0] tsv   [3];

  logic [31:0] id_word;
  logic [31:0] ts_word;

  // Sysid slave model: word selected combinationally by address.
  assign rdata[0] = addr[0] ? ts_word : id_word;
  assign rdata[1] = addr[1] ? ts_word : id_word;
  assign rdata[2] = addr[2] ? ts_word : id_word;

  palt_sysid_checker u_dut0 (
    .clock(clk), .reset(rst[0]), .start(start[0]), .avm_address(addr[0]), .avm_read(rd[0]),
    .avm_waitrequest(wreq[0]), .avm_readdata(rdata[0]), .busy(busy[0]), .done(done[0]),
    .id_ok(idok[0]), .ts_ok(tsok[0]), .match(mtch[0]), .timeout_err(tmerr[0]),
    .id_value(idv[0]), .ts_value(tsv[0])
  );

  palt_sysid_checker #(.READ_LATENCY(2), .TIMEOUT(10)) u_dut1 (
    .clock(clk), .reset(rst[1]), .start(start[1]), .avm_address(addr[1]), .avm_read(rd[1]),
    .avm_waitrequest(wreq[1]), .avm_readdata(rdata[1]), .busy(busy[1]), .done(done[1]),
    .id_ok(idok[1]), .ts_ok(tsok[1]), .match(mtch[1]), .timeout_err(tmerr[1]),
    .id_value(idv[1]), .ts_value(tsv[1])
  );

  palt_sysid_checker #(.AUTO_START(1'b0)) u_dut2 (
    .clock(clk), .reset(rst[2]), .start(start[2]), .avm_address(addr[2]), .avm_read(rd[2]),
    .avm_waitrequest(wreq[2]), .avm_readdata(rdata[2]), .busy(busy[2]), .done(done[2]),
    .id_ok(idok[2]), .ts_ok(tsok[2]), .match(mtch[2]), .timeout_err(tmerr[2]),
    .id_value(idv[2]), .ts_value(tsv[2])
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] id_w;
    logic [31:0] ts_w;
    logic        id_ok;
    logic        ts_ok;
    logic        match;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{ExpId, ExpTs, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{32'd9, ExpTs, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{ExpId, ExpTs ^ 32'd1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0008, ExpTs, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'd0, 32'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      start[i] = 1'b0;
      wreq[i] = 1'b0;
    end
    id_word = ExpId;
    ts_word = ExpTs;
    tick();
    tick();

    // Reset state.
    check("rst_read", 32'(rd[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    check("rst_idv", idv[0], 0);

    // Table: zero-wait, latency 0, auto start; done on edge 3.
    for (int i = 0; i < 5; i++) begin
      rst[0] = 1'b1;
      id_word = vecs[i].id_w;
      ts_word = vecs[i].ts_w;
      tick();
      rst[0] = 1'b0;
      tick();
      check($sformatf("v%0d_e1_read", i), 32'(rd[0]), 1);
      check($sformatf("v%0d_e1_addr", i), 32'(addr[0]), 0);
      check($sformatf("v%0d_e1_busy", i), 32'(busy[0]), 1);
      tick();
      check($sformatf("v%0d_e2_read", i), 32'(rd[0]), 1);
      check($sformatf("v%0d_e2_addr", i), 32'(addr[0]), 1);
      check($sformatf("v%0d_e2_done", i), 32'(done[0]), 0);
      tick();
      check($sformatf("v%0d_e3_done", i), 32'(done[0]), 1);
      check($sformatf("v%0d_e3_busy", i), 32'(busy[0]), 0);
      check($sformatf("v%0d_e3_read", i), 32'(rd[0]), 0);
      check($sformatf("v%0d_idok", i), 32'(idok[0]), 32'(vecs[i].id_ok));
      check($sformatf("v%0d_tsok", i), 32'(tsok[0]), 32'(vecs[i].ts_ok));
      check($sformatf("v%0d_match", i), 32'(mtch[0]), 32'(vecs[i].match));
      check($sformatf("v%0d_tmo", i), 32'(tmerr[0]), 0);
      check($sformatf("v%0d_idv", i), idv[0], vecs[i].id_w);
      check($sformatf("v%0d_tsv", i), tsv[0], vecs[i].ts_w);
    end
    id_word = ExpId;
    ts_word = ExpTs;

    // Asynchronous reset in the middle of the TS read, then a clean rerun.
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    tick();
    tick();
    check("mid_pre_read", 32'(rd[0]), 1);
    check("mid_pre_addr", 32'(addr[0]), 1);
    #1 rst[0] = 1'b1;
    #1;
    check("mid_async_read", 32'(rd[0]), 0);
    check("mid_async_busy", 32'(busy[0]), 0);
    check("mid_async_idv", idv[0], 0);
    tick();
    rst[0] = 1'b0;
    tick();
    tick();
    tick();
    check("rerun_done", 32'(done[0]), 1);
    check("rerun_match", 32'(mtch[0]), 1);

    // Stall 4 cycles per read with READ_LATENCY=2: done on edge 14.
    wreq[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("st_id_read_e%0d", e), 32'(rd[1]), 1);
      check($sformatf("st_id_addr_e%0d", e), 32'(addr[1]), 0);
    end
    wreq[1] = 1'b0;
    tick();
    check("lat_id_read_e5", 32'(rd[1]), 0);
    tick();
    check("lat_id_busy_e6", 32'(busy[1]), 1);
    tick();
    check("lat_ts_read_e7", 32'(rd[1]), 1);
    check("lat_idv_e7", idv[1], ExpId);
    wreq[1] = 1'b1;
    for (int e = 8; e <= 11; e++) begin
      tick();
      check($sformatf("st_ts_read_e%0d", e), 32'(rd[1]), 1);
      check($sformatf("st_ts_addr_e%0d", e), 32'(addr[1]), 1);
    end
    wreq[1] = 1'b0;
    tick();
    check("lat_ts_read_e12", 32'(rd[1]), 0);
    tick();
    check("lat_done_e13", 32'(done[1]), 0);
    tick();
    check("lat_done_e14", 32'(done[1]), 1);
    check("lat_match", 32'(mtch[1]), 1);
    check("lat_tsv", tsv[1], ExpTs);

    // Timeout: waitrequest stuck high, TIMEOUT=10.
    rst[1] = 1'b1;
    wreq[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("tmo_read_e%0d", e), 32'(rd[1]), 1);
    end
    tick();
    check("tmo_read_drop", 32'(rd[1]), 0);
    check("tmo_err", 32'(tmerr[1]), 1);
    check("tmo_done", 32'(done[1]), 1);
    check("tmo_busy", 32'(busy[1]), 0);
    check("tmo_match", 32'(mtch[1]), 0);
    check("tmo_idok", 32'(idok[1]), 0);
    check("tmo_idv", idv[1], 0);

    // Manual start: ignored while busy and on the edge entering DONE.
    tick();
    rst[2] = 1'b0;
    tick();
    tick();
    tick();
    check("man_idle_busy", 32'(busy[2]), 0);
    check("man_idle_read", 32'(rd[2]), 0);
    start[2] = 1'b1;
    tick();
    check("man_go_busy", 32'(busy[2]), 1);
    check("man_go_read", 32'(rd[2]), 1);
    tick();
    check("man_busy_start_addr", 32'(addr[2]), 1);
    tick();
    check("man_done", 32'(done[2]), 1);
    check("man_match", 32'(mtch[2]), 1);
    start[2] = 1'b0;
    tick();
    check("man_no_restart_done", 32'(done[2]), 1);
    check("man_no_restart_busy", 32'(busy[2]), 0);
    id_word = 32'd9;
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    check("man_restart_done", 32'(done[2]), 0);
    check("man_restart_busy", 32'(busy[2]), 1);
    check("man_restart_idv_kept", idv[2], ExpId);
    tick();
    tick();
    check("man_rpt_done", 32'(done[2]), 1);
    check("man_rpt_idok", 32'(idok[2]), 0);
    check("man_rpt_match", 32'(mtch[2]), 0);
    check("man_rpt_idv", idv[2], 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
